// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO: header-tagged storage, occupancy/almost-full status and
// a remaining-bytes counter for the packet being drained. Optional macro: FIFO_ERR_FLAGS_EN.
module router_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   soft_reset,
  input  logic                   write_enb,
  input  logic                   read_enb,
  input  logic                   lfd_state,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [DATA_W-2:0]      pkt_rem,
  output logic                   pkt_done
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   overflow_err,
  output logic                   underflow_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = DATA_W - 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
  localparam logic [LW-1:0] ONE_L  = LW'(1);

  // Header length field plus one trailing parity byte.
  function automatic logic [LW-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return {1'b0, hdr[DATA_W-1:2]} + ONE_L;
  endfunction

  function automatic logic [LW-1:0] dec_floor(input logic [LW-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - ONE_L;
  endfunction

  logic [DATA_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   wr_ptr_nxt, rd_ptr_nxt, fill_nxt;
  logic            lfd_q;
  logic            wr_acc_p0, rd_acc_p0;
  logic [DATA_W:0] rd_word_p0;

  // Stage p0: accept requests against pre-edge full/empty
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign wr_acc_p0  = write_enb && !full && !soft_reset;
  assign rd_acc_p0  = read_enb && !empty && !soft_reset;
  assign rd_word_p0 = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_acc_p0};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_acc_p0};
    fill_nxt   = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clock) begin
    if (wr_acc_p0) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_q, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      almost_full <= 1'b0;
      lfd_q       <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      almost_full <= 1'b0;
      lfd_q       <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      fill_level  <= fill_nxt;
      almost_full <= (fill_nxt >= AF_LVL);
      lfd_q       <= lfd_state;
    end
  end

  // Stage p1: registered read data and packet byte tracking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
      pkt_rem  <= '0;
      pkt_done <= 1'b0;
    end else if (soft_reset) begin
      data_out <= '0;
      pkt_rem  <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (rd_acc_p0) begin
        data_out <= rd_word_p0[DATA_W-1:0];
        if (rd_word_p0[DATA_W]) begin
          pkt_rem <= hdr_len(rd_word_p0[DATA_W-1:0]);
        end else begin
          pkt_rem  <= dec_floor(pkt_rem);
          pkt_done <= (pkt_rem == ONE_L);
        end
      end
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (soft_reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (write_enb && full) overflow_err <= 1'b1;
      if (read_enb && empty) underflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: directed packets, full/empty corners, wrap and flush.
module tb_router_pkt_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;

  logic              clock;
  logic              resetn;
  logic              soft_reset;
  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [4:0]        fill_level;
  logic [6:0]        pkt_rem;
  logic              pkt_done;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow_err;
  logic              underflow_err;
`endif

  router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .fill_level(fill_level), .pkt_rem(pkt_rem),
    .pkt_done(pkt_done)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow_err(overflow_err), .underflow_err(underflow_err)
`endif
  );

  typedef struct {
    logic [7:0] d;
    int         rem;
    bit         done;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] hold_d = 8'h00;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int fl, input bit f, input bit e, input bit af);
    chk({tag, "_fill"}, 32'(fill_level), fl);
    chk({tag, "_full"}, 32'(full), 32'(f));
    chk({tag, "_empty"}, 32'(empty), 32'(e));
    chk({tag, "_afull"}, 32'(almost_full), 32'(af));
  endtask

  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din);
    write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    @(negedge clock);
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
  endtask

  task automatic srst(input bit we, input bit re, input bit lfd, input logic [7:0] din);
    soft_reset = 1'b1;
    step(we, re, lfd, din);
    soft_reset = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input int rem, input bit done);
    exp_t e;
    e.d = d; e.rem = rem; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic lfd_pulse();
    step(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic rd(input logic [7:0] d, input int rem, input bit done);
    push_exp(d, rem, done);
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  // Monitor: an accepted read is visible on the outputs one edge later.
  initial begin
    bit   acc;
    bit   clr;
    exp_t e;
    forever begin
      @(posedge clock);
      acc = resetn && !soft_reset && read_enb && !empty;
      clr = !resetn || soft_reset;
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: data_out 0x%0h with no read expected", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(data_out), 32'(e.d));
          chk("rd_pkt_rem", 32'(pkt_rem), e.rem);
          chk("rd_pkt_done", 32'(pkt_done), 32'(e.done));
          hold_d = e.d;
        end
      end else begin
        if (clr) hold_d = 8'h00;
        chk("hold_data", 32'(data_out), 32'(hold_d));
        chk("idle_pkt_done", 32'(pkt_done), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit re;
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Reset / idle
    chk_st("reset", 0, 1'b0, 1'b1, 1'b0);
    chk("reset_data_out", 32'(data_out), 32'h00);
    chk("reset_pkt_rem", 32'(pkt_rem), 32'd0);
    chk("reset_pkt_done", 32'(pkt_done), 32'd0);

    // Single packet: header 0x0C (len 3), payload, parity
    lfd_pulse();
    wr(8'h0C); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h5A);
    chk_st("pkt_loaded", 5, 1'b0, 1'b0, 1'b0);
    rd(8'h0C, 4, 1'b0);
    rd(8'h11, 3, 1'b0);
    rd(8'h22, 2, 1'b0);
    rd(8'h33, 1, 1'b0);
    rd(8'h5A, 0, 1'b1);
    chk_st("pkt_drained", 0, 1'b0, 1'b1, 1'b0);

    // Fill to full, overflow attempt, read+write while full
    for (int k = 1; k <= 16; k++) begin
      wr(8'(8'h40 + k - 1));
      chk_st("fill", k, (k == 16), 1'b0, (k >= AF));
    end
    wr(8'hEE);
    chk_st("overflow_drop", 16, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_err_set", 32'(overflow_err), 32'd1);
`endif
    push_exp(8'h40, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    chk_st("rw_full", 15, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 16; i++) rd(8'(8'h40 + i), 0, 1'b0);
    chk_st("full_drained", 0, 1'b0, 1'b1, 1'b0);

    // Read+write while empty: read ignored
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    chk_st("rw_empty", 1, 1'b0, 1'b0, 1'b0);
    rd(8'hA5, 0, 1'b0);
    chk_st("rw_empty_rd", 0, 1'b0, 1'b1, 1'b0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++) begin
      re = (i % 2 == 1);
      if (re && mdl.size() > 0) push_exp(mdl.pop_front(), 0, 1'b0);
      mdl.push_back(8'(8'h60 + i));
      step(1'b1, re, 1'b0, 8'(8'h60 + i));
      chk_st("wrap", mdl.size(), (mdl.size() == 16), (mdl.size() == 0), (mdl.size() >= AF));
    end
    while (mdl.size() > 0) begin
      rd(mdl.pop_front(), 0, 1'b0);
      chk("wrap_drain_fill", 32'(fill_level), mdl.size());
    end
    chk_st("wrap_done", 0, 1'b0, 1'b1, 1'b0);

    // Soft reset mid-packet (pkt_rem 2, fill 6), request and lfd_state held during it
    lfd_pulse();
    wr(8'h0C); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h5A);
    wr(8'h77); wr(8'h88); wr(8'h99); wr(8'hAA);
    rd(8'h0C, 4, 1'b0);
    rd(8'h11, 3, 1'b0);
    rd(8'h22, 2, 1'b0);
    chk("pre_srst_pkt_rem", 32'(pkt_rem), 32'd2);
    chk("pre_srst_fill", 32'(fill_level), 32'd6);
    srst(1'b1, 1'b1, 1'b1, 8'hFF);
    chk_st("srst", 0, 1'b0, 1'b1, 1'b0);
    chk("srst_pkt_rem", 32'(pkt_rem), 32'd0);
    chk("srst_data_out", 32'(data_out), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("srst_overflow_err", 32'(overflow_err), 32'd0);
    chk("srst_underflow_err", 32'(underflow_err), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("underflow_err_set", 32'(underflow_err), 32'd1);
    chk("underflow_no_overflow", 32'(overflow_err), 32'd0);
    srst(1'b0, 1'b0, 1'b0, 8'h00);
    chk("underflow_err_clr", 32'(underflow_err), 32'd0);
`endif
    wr(8'h10);
    lfd_pulse();
    wr(8'h08); wr(8'h01); wr(8'h02); wr(8'h03);
    rd(8'h10, 0, 1'b0);
    rd(8'h08, 3, 1'b0);
    rd(8'h01, 2, 1'b0);
    rd(8'h02, 1, 1'b0);
    rd(8'h03, 0, 1'b1);

    // Truncated packet: a new header reloads the counter mid-packet
    lfd_pulse();
    wr(8'h0C); wr(8'h11);
    lfd_pulse();
    wr(8'h04); wr(8'h22); wr(8'h33);
    rd(8'h0C, 4, 1'b0);
    rd(8'h11, 3, 1'b0);
    rd(8'h04, 2, 1'b0);
    rd(8'h22, 1, 1'b0);
    rd(8'h33, 0, 1'b1);
    chk_st("trunc_done", 0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
